// File: rtl/row_scan_ctrl.sv
// row_scan_ctrl: LED matrix row sequencer (shift, blank, latch, advance, show) with pixel handshake.
module row_scan_ctrl #(
    parameter int ROWS      = 21,
    parameter int COLS      = 32,
    parameter int ON_CYCLES = 64,
    parameter int ROW_W     = 5,
    parameter int COL_W     = 5,
    parameter int ON_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_pix_valid,
    output logic             o_pix_req,
    output logic [COL_W-1:0] o_col,
    output logic             o_shift,
    output logic             o_blank,
    output logic             o_latch,
    output logic             o_add_row,
    output logic [ROW_W-1:0] o_row,
    output logic             o_frame_start,
    output logic             o_busy
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, ADVANCE, SHOW} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d, srow_q, srow_d;
    logic [ON_W-1:0]  on_q, on_d;
    logic             lit_q, lit_d, fs_q, fs_d;
    logic             accept, show_end;

    assign accept   = (state_q == SHIFT) && i_pix_valid;
    assign show_end = (state_q == SHOW) && (on_q == ON_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            srow_q  <= '0;
            on_q    <= '0;
            lit_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            srow_q  <= srow_d;
            on_q    <= on_d;
            lit_q   <= lit_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = i_enable ? SHIFT : IDLE;
            SHIFT:   state_d = (accept && col_q == COL_LAST) ? BLANK : SHIFT;
            BLANK:   state_d = LATCH;
            LATCH:   state_d = ADVANCE;
            ADVANCE: state_d = SHOW;
            SHOW:    state_d = !show_end ? SHOW : (srow_q != '0 || i_enable) ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enable is only honoured at frame boundaries: from IDLE or after the last row's on-time.
    always_comb begin
        col_d  = accept ? ((col_q == COL_LAST) ? '0 : col_q + 1'b1) : col_q;
        row_d  = (state_q == ADVANCE) ? srow_q : row_q;
        srow_d = (state_q == IDLE) ? '0 :
                 (state_q == ADVANCE) ? ((srow_q == ROW_LAST) ? '0 : srow_q + 1'b1) : srow_q;
        on_d   = (state_q == SHOW && !show_end) ? on_q + 1'b1 : '0;
        lit_d  = (state_q == ADVANCE) ? 1'b1 : (show_end && state_d == IDLE) ? 1'b0 : lit_q;
        fs_d   = (state_d == SHIFT) && (state_q == IDLE || (show_end && srow_q == '0));
    end

    always_comb begin
        o_pix_req     = (state_q == SHIFT);
        o_col         = col_q;
        o_shift       = accept;
        o_blank       = !(lit_q && (state_q == SHIFT || state_q == SHOW));
        o_latch       = (state_q == LATCH);
        o_add_row     = (state_q == ADVANCE) && (srow_q != '0);
        o_row         = row_q;
        o_frame_start = fs_q;
        o_busy        = (state_q != IDLE);
    end
endmodule

// File: tb/tb_row_scan_ctrl.sv
// tb_row_scan_ctrl: vector table plus procedural row-by-row reference of the scan sequence.
module tb_row_scan_ctrl;
    localparam int ROWS = 21;
    localparam int COLS = 32;
    localparam int ON   = 64;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, v = 1'b0;
    logic       o_pix_req, o_shift, o_blank, o_latch, o_add_row, o_frame_start, o_busy;
    logic [4:0] o_col, o_row;
    int         errs = 0, checks = 0, n_add = 0, n_latch = 0;

    row_scan_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pix_valid(v),
        .o_pix_req(o_pix_req), .o_col(o_col), .o_shift(o_shift), .o_blank(o_blank),
        .o_latch(o_latch), .o_add_row(o_add_row), .o_row(o_row),
        .o_frame_start(o_frame_start), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    wire [16:0] obs = {o_pix_req, o_col, o_shift, o_blank, o_latch, o_add_row, o_row, o_frame_start, o_busy};

    function automatic logic [16:0] pk(logic pr, logic [4:0] col, logic sh, logic bl, logic la,
                                       logic ad, logic [4:0] row, logic fs, logic bz);
        return {pr, col, sh, bl, la, ad, row, fs, bz};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic samp(input string tag, input logic [16:0] e);
        @(negedge clk);
        n_add += int'(o_add_row);
        n_latch += int'(o_latch);
        chk(tag, 32'(obs), 32'(e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 valid always high, 1 random valid, 2 valid toggling starting low
    task automatic run_row(input int r, input logic lit, input int prev, input logic en_v,
                           input int mode, input int show_n, output int cyc);
        int k;
        logic [4:0] pr5, r5, k5;
        k = 0;
        cyc = 0;
        pr5 = prev[4:0];
        r5 = r[4:0];
        en = en_v;
        while (k < COLS && cyc < 1000) begin
            v = (mode == 0) ? 1'b1 : (mode == 2) ? logic'(cyc % 2) : logic'($urandom_range(0, 1));
            k5 = k[4:0];
            samp("shift", pk(1'b1, k5, v, !lit, 1'b0, 1'b0, pr5, (r == 0 && cyc == 0), 1'b1));
            if (v) k++;
            cyc++;
            step();
        end
        if (k < COLS) chk("shift_timeout", k, COLS);
        if (mode == 2) chk("toggle_len", cyc, 2 * COLS);
        v = logic'($urandom_range(0, 1));
        samp("blank", pk(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, pr5, 1'b0, 1'b1));
        step();
        v = logic'($urandom_range(0, 1));
        samp("latch", pk(1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, pr5, 1'b0, 1'b1));
        step();
        v = logic'($urandom_range(0, 1));
        samp("advance", pk(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, (r != 0), pr5, 1'b0, 1'b1));
        step();
        for (int i = 0; i < show_n; i++) begin
            v = logic'($urandom_range(0, 1));
            samp("show", pk(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, r5, 1'b0, 1'b1));
            step();
        end
        cyc += 3 + show_n;
    endtask

    typedef struct {
        logic        en;
        logic        v;
        logic [16:0] exp;
    } vec_t;

    localparam logic [16:0] IDLE_O = 17'({1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0});

    initial begin
        vec_t vt[7];
        int cyc, tot, a0, l0;
        vt[0] = '{1'b0, 1'b1, IDLE_O};
        vt[1] = '{1'b1, 1'b0, IDLE_O};
        vt[2] = '{1'b0, 1'b0, pk(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1)};
        vt[3] = '{1'b0, 1'b1, pk(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1)};
        vt[4] = '{1'b0, 1'b1, pk(1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1)};
        vt[5] = '{1'b0, 1'b0, pk(1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1)};
        vt[6] = '{1'b0, 1'b1, pk(1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1)};

        v = 1'b1;
        repeat (2) step();
        samp("reset", IDLE_O);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            en = vt[i].en;
            v = vt[i].v;
            samp($sformatf("vec%0d", i), vt[i].exp);
            step();
        end
        rst_n = 1'b0;
        #1 chk("rst_mid_shift", 32'(obs), 32'(IDLE_O));
        step();
        rst_n = 1'b1;

        // Frame A: valid held high, exact row and frame timing.
        en = 1'b1;
        v = 1'b0;
        samp("idle_en", IDLE_O);
        step();
        tot = 0;
        a0 = n_add;
        l0 = n_latch;
        for (int r = 0; r < ROWS; r++) begin
            run_row(r, r != 0, (r == 0) ? 0 : r - 1, 1'b1, 0, ON, cyc);
            chk($sformatf("row_period%0d", r), cyc, COLS + 3 + ON);
            tot += cyc;
        end
        chk("frame_period", tot, (COLS + 3 + ON) * ROWS);
        chk("add_row_count", n_add - a0, ROWS - 1);
        chk("latch_count", n_latch - l0, ROWS);

        // Frame B: random stalls, enable dropped from row 5.
        for (int r = 0; r < ROWS; r++)
            run_row(r, 1'b1, (r == 0) ? ROWS - 1 : r - 1, r < 5, 1, ON, cyc);
        v = 1'b1;
        repeat (3) begin
            samp("idle_after_drop", pk(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0));
            step();
        end

        // Frame C: toggled valid on the blanked first row, then reset mid-SHOW of row 7.
        en = 1'b1;
        samp("idle_en2", pk(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0));
        step();
        run_row(0, 1'b0, ROWS - 1, 1'b1, 2, ON, cyc);
        for (int r = 1; r < 7; r++) run_row(r, 1'b1, r - 1, 1'b1, 1, ON, cyc);
        run_row(7, 1'b1, 6, 1'b1, 1, 10, cyc);
        rst_n = 1'b0;
        #1 chk("rst_mid_show", 32'(obs), 32'(IDLE_O));
        step();
        rst_n = 1'b1;
        en = 1'b0;
        v = 1'b1;
        repeat (3) begin
            samp("idle_after_rst", IDLE_O);
            step();
        end
        en = 1'b1;
        v = 1'b0;
        samp("idle_en3", IDLE_O);
        step();
        samp("restart", pk(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
